// File: rtl/debounce_bcd_counter.sv
// Multi-channel switch debouncer driving an up/down modulo counter.
// A shared prescaler tick paces per-channel consecutive-sample filters; everything runs on clk.

`timescale 1ns/1ps

module debounce_bcd_counter_chk #(
  parameter int N_CH  = 2,
  parameter int MOD   = 10,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic [N_CH-1:0]  sw_db,
  input logic [N_CH-1:0]  sw_rise,
  input logic [CNT_W-1:0] count,
  input logic             wrap
);

  localparam logic [CNT_W-1:0] MOD_M1 = CNT_W'(MOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= MOD_M1);

  a_wrap_value: assert property (@(posedge clk) disable iff (!rst_n)
    wrap |-> ((count == CNT_ZERO) || (count == MOD_M1)));

  a_wrap_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    wrap |=> !wrap);

  a_rise_level: assert property (@(posedge clk) disable iff (!rst_n)
    (sw_rise & ~sw_db) == {N_CH{1'b0}});

endmodule

module debounce_bcd_counter #(
  parameter int N_CH     = 2,
  parameter int DIV_BITS = 16,
  parameter int STABLE   = 4,
  parameter int MOD      = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  sw,
  output logic             sample_tick,
  output logic [N_CH-1:0]  sw_db,
  output logic [N_CH-1:0]  sw_rise,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam int STAB_W = $clog2(STABLE + 1);
  localparam logic [DIV_BITS-1:0] DIV_ONE  = DIV_BITS'(1);
  // One count before all-ones, so the registered compare lands on the all-ones cycle.
  localparam logic [DIV_BITS-1:0] DIV_PRE  = ~DIV_BITS'(1);
  localparam logic [STAB_W-1:0]   STAB_ONE  = STAB_W'(1);
  localparam logic [STAB_W-1:0]   STAB_LAST = STAB_W'(STABLE - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    MOD_M1   = CNT_W'(MOD - 1);

  logic [DIV_BITS-1:0] div_r;
  logic                tick_r;
  logic [N_CH-1:0]     sync1_r;
  logic [N_CH-1:0]     sync2_r;
  logic [CNT_W-1:0]    count_r;
  logic                wrap_r;
  logic [CNT_W-1:0]    count_nxt_s;
  logic                wrap_nxt_s;
  logic                up_s;
  logic                dn_s;

  // Free-running prescaler; the first tick appears 2^DIV_BITS - 1 cycles after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r  <= {DIV_BITS{1'b0}};
      tick_r <= 1'b0;
    end else begin
      div_r  <= div_r + DIV_ONE;
      tick_r <= (div_r == DIV_PRE);
    end
  end

  assign sample_tick = tick_r;

  // Two-flop synchroniser for the raw switch inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {N_CH{1'b0}};
      sync2_r <= {N_CH{1'b0}};
    end else begin
      sync1_r <= sw;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [STAB_W-1:0] stab_r;
    logic              db_r;
    logic              rise_r;
    logic              differ_s;
    logic              accept_s;

    // A new level is accepted on the STABLE-th consecutive differing sample.
    always_comb begin
      differ_s = sync2_r[i] ^ db_r;
      accept_s = tick_r & differ_s & (stab_r == STAB_LAST);
    end

    // Stability filter and rising-edge pulse, aligned with the debounced level update.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stab_r <= {STAB_W{1'b0}};
        db_r   <= 1'b0;
        rise_r <= 1'b0;
      end else begin
        rise_r <= accept_s & sync2_r[i];
        if (tick_r) begin
          if (!differ_s) begin
            stab_r <= {STAB_W{1'b0}};
          end else if (accept_s) begin
            stab_r <= {STAB_W{1'b0}};
            db_r   <= sync2_r[i];
          end else begin
            stab_r <= stab_r + STAB_ONE;
          end
        end else begin
          stab_r <= stab_r;
        end
      end
    end

    assign sw_db[i]   = db_r;
    assign sw_rise[i] = rise_r;
  end

  assign up_s = sw_rise[0];

  if (N_CH > 1) begin : g_dn
    assign dn_s = sw_rise[1];
  end else begin : g_no_dn
    assign dn_s = 1'b0;
  end

  // Next count: simultaneous up and down cancel.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    case ({up_s, dn_s})
      2'b10: begin
        if (count_r == MOD_M1) begin
          count_nxt_s = CNT_ZERO;
          wrap_nxt_s  = 1'b1;
        end else begin
          count_nxt_s = count_r + CNT_ONE;
          wrap_nxt_s  = 1'b0;
        end
      end
      2'b01: begin
        if (count_r == CNT_ZERO) begin
          count_nxt_s = MOD_M1;
          wrap_nxt_s  = 1'b1;
        end else begin
          count_nxt_s = count_r - CNT_ONE;
          wrap_nxt_s  = 1'b0;
        end
      end
      default: begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
      end
    endcase
  end

  // Counter register and wrap pulse, updated the cycle after sw_rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign count = count_r;
  assign wrap  = wrap_r;

  debounce_bcd_counter_chk #(
    .N_CH  (N_CH),
    .MOD   (MOD),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_db   (sw_db),
    .sw_rise (sw_rise),
    .count   (count),
    .wrap    (wrap)
  );

endmodule

// File: tb/tb_debounce_bcd_counter.sv
// Directed bench for debounce_bcd_counter: table of tick-paced switch steps plus
// hand-written sequences for prescaler timing and asynchronous reset mid-operation.

`timescale 1ns/1ps

module tb_debounce_bcd_counter;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw;
  logic       sample_tick;
  logic [1:0] sw_db;
  logic [1:0] sw_rise;
  logic [3:0] count;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] sw;     // switch value applied for this step
    int         ticks;  // sample ticks the value is held
    logic [1:0] rise;   // sw_rise expected right after the last tick
    logic [1:0] db;     // sw_db expected right after the last tick
    logic [3:0] cnt;    // count expected one cycle later
    logic       wrap;   // wrap expected one cycle later
  } vec_t;

  vec_t vecs[$];

  debounce_bcd_counter #(
    .N_CH     (2),
    .DIV_BITS (4),
    .STABLE   (4),
    .MOD      (10),
    .CNT_W    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .sample_tick (sample_tick),
    .sw_db       (sw_db),
    .sw_rise     (sw_rise),
    .count       (count),
    .wrap        (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Advance negedge by negedge until sample_tick is seen; n = negedges taken.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 64);
    if (!sample_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout actual=%0d required=<64", n);
    end
  endtask

  task automatic add(input logic [1:0] s, input int t, input logic [1:0] r,
                     input logic [1:0] d, input logic [3:0] c, input logic w);
    vec_t v;
    v.sw = s; v.ticks = t; v.rise = r; v.db = d; v.cnt = c; v.wrap = w;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string name, input int idx);
    chk({name, "_tick"}, idx, {31'd0, sample_tick}, 32'd0);
    chk({name, "_db"},   idx, {30'd0, sw_db},       32'd0);
    chk({name, "_rise"}, idx, {30'd0, sw_rise},     32'd0);
    chk({name, "_count"}, idx, {28'd0, count},      32'd0);
    chk({name, "_wrap"}, idx, {31'd0, wrap},        32'd0);
  endtask

  initial begin
    int n;
    int c;
    logic [3:0] prev_cnt;

    add(2'b00, 4, 2'b00, 2'b00, 4'd0, 1'b0);
    add(2'b01, 3, 2'b00, 2'b00, 4'd0, 1'b0);
    add(2'b01, 1, 2'b01, 2'b01, 4'd1, 1'b0);
    add(2'b00, 4, 2'b00, 2'b00, 4'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      add(2'b01, 3, 2'b00, 2'b00, 4'd1, 1'b0);
      add(2'b00, 1, 2'b00, 2'b00, 4'd1, 1'b0);
    end
    add(2'b01, 3, 2'b00, 2'b00, 4'd1, 1'b0);
    add(2'b01, 1, 2'b01, 2'b01, 4'd2, 1'b0);
    add(2'b00, 4, 2'b00, 2'b00, 4'd2, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      c = (2 + k) % 10;
      add(2'b01, 4, 2'b01, 2'b01, 4'(c), (c == 0));
      add(2'b00, 4, 2'b00, 2'b00, 4'(c), 1'b0);
    end
    add(2'b10, 4, 2'b10, 2'b10, 4'd9, 1'b1);
    add(2'b00, 4, 2'b00, 2'b00, 4'd9, 1'b0);
    add(2'b10, 4, 2'b10, 2'b10, 4'd8, 1'b0);
    add(2'b00, 4, 2'b00, 2'b00, 4'd8, 1'b0);
    add(2'b01, 4, 2'b01, 2'b01, 4'd9, 1'b0);
    add(2'b00, 4, 2'b00, 2'b00, 4'd9, 1'b0);
    add(2'b01, 4, 2'b01, 2'b01, 4'd0, 1'b1);
    add(2'b00, 4, 2'b00, 2'b00, 4'd0, 1'b0);
    add(2'b11, 4, 2'b11, 2'b11, 4'd0, 1'b0);
    add(2'b00, 4, 2'b00, 2'b00, 4'd0, 1'b0);
    add(2'b01, 4, 2'b01, 2'b01, 4'd1, 1'b0);
    add(2'b00, 4, 2'b00, 2'b00, 4'd1, 1'b0);
    add(2'b10, 4, 2'b10, 2'b10, 4'd0, 1'b0);
    add(2'b11, 4, 2'b01, 2'b11, 4'd1, 1'b0);
    add(2'b00, 4, 2'b00, 2'b00, 4'd1, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      add(2'b01, 4, 2'b01, 2'b01, 4'(k), 1'b0);
      add(2'b00, 4, 2'b00, 2'b00, 4'(k), 1'b0);
    end

    rst_n = 1'b0;
    sw    = 2'b00;
    repeat (3) @(negedge clk);
    check_all_zero("reset", 0);
    #2 rst_n = 1'b1;

    // Prescaler: first tick 15 cycles after release, then every 16, one cycle wide.
    wait_tick(n);
    chk("first_tick", 0, n, 32'd15);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("tick_width", k, {31'd0, sample_tick}, 32'd0);
      wait_tick(n);
      chk("tick_period", k, n + 1, 32'd16);
    end

    prev_cnt = 4'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      sw = vecs[i].sw;
      for (int t = 0; t < vecs[i].ticks; t++) wait_tick(n);
      @(negedge clk);
      chk("rise",       i, {30'd0, sw_rise}, {30'd0, vecs[i].rise});
      chk("db",         i, {30'd0, sw_db},   {30'd0, vecs[i].db});
      chk("count_hold", i, {28'd0, count},   {28'd0, prev_cnt});
      chk("wrap_early", i, {31'd0, wrap},    32'd0);
      @(negedge clk);
      chk("count",      i, {28'd0, count},   {28'd0, vecs[i].cnt});
      chk("wrap",       i, {31'd0, wrap},    {31'd0, vecs[i].wrap});
      chk("rise_width", i, {30'd0, sw_rise}, 32'd0);
      if (vecs[i].wrap) begin
        @(negedge clk);
        chk("wrap_width", i, {31'd0, wrap}, 32'd0);
      end
      prev_cnt = vecs[i].cnt;
    end

    // Asynchronous reset mid-debounce with count at 5 and sw[0] held high.
    sw = 2'b01;
    wait_tick(n);
    wait_tick(n);
    chk("pre_reset_count", 0, {28'd0, count}, 32'd5);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_reset", 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold", 0);
    #2 rst_n = 1'b1;
    for (int t = 0; t < 3; t++) wait_tick(n);
    @(negedge clk);
    chk("rerst_db_early", 0, {30'd0, sw_db}, 32'd0);
    wait_tick(n);
    @(negedge clk);
    chk("rerst_db",   0, {30'd0, sw_db},   32'd1);
    chk("rerst_rise", 0, {30'd0, sw_rise}, 32'd1);
    chk("rerst_count_hold", 0, {28'd0, count}, 32'd0);
    @(negedge clk);
    chk("rerst_count", 0, {28'd0, count},   32'd1);
    chk("rerst_rise_width", 0, {30'd0, sw_rise}, 32'd0);
    chk("rerst_wrap",  0, {31'd0, wrap},    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
